wb_stage_pipe: RTL and testbench
================================

// Module: wb_stage_pipe
// PURPOSE
//  Registered writeback stage: successor to the combinational WB select.
//  Sits after MEM and drives the register file write port.
//  Adds a valid/ready handshake, late load-data return with stall,
//  byte/half load extraction with sign-extension, x0 suppression and flush.
// PARAMETERS
//  XLEN        32  datapath width (>=32, multiple of 8)
//  REG_ADDR_W  5   register index width
//  PC_INC      4   link increment for jal/jalr
// PORTS
//  clk               in   1           clock, all state on rising edge
//  reset             in   1           synchronous, active-high
//  in_valid          in   1           MEM presents an instruction
//  in_ready          out  1           WB can accept (1 only in IDLE)
//  flush_in          in   1           discard pending load, back to IDLE
//  Ctl_RegWrite_in   in   1           instruction writes a register
//  Ctl_MemtoReg_in   in   1           result comes from memory (load)
//  jal_in, jalr_in   in   1           link write: result = PC_in+PC_INC
//  funct3_in         in   3           load size/sign
//  PC_in             in   XLEN        instruction PC
//  Rd_in             in   REG_ADDR_W  destination register
//  ALUresult_in      in   XLEN        ALU result / load address
//  mem_rvalid        in   1           load data valid (may lag accept)
//  mem_rdata         in   XLEN        aligned word containing load data
//  Ctl_RegWrite_out  out  1           one-cycle regfile write strobe
//  Rd_out            out  REG_ADDR_W  write index
//  WriteDatatoReg_out out XLEN        write data
//  retire_cnt        out  64          retired count (macro only)
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE; Ctl_RegWrite_out=0, Rd_out=0,
//    WriteDatatoReg_out=0, retire_cnt=0; in_ready=1 the cycle after.
//  - FSM IDLE/WAIT_MEM. in_ready = (state==IDLE). Accept = in_valid&in_ready.
//  - IDLE accept, non-load: outputs registered next edge (latency 1).
//  - IDLE accept, load with mem_rvalid=1 same cycle: retire next edge.
//  - IDLE accept, load with mem_rvalid=0: latch PC/Rd/ALU/funct3/ctl,
//    go WAIT_MEM, in_ready=0.
//  - WAIT_MEM & mem_rvalid: retire next edge, return to IDLE on same edge.
//  - mem_rvalid while no load pending: ignored, no write.
//  - Result priority: MemtoReg > (jal|jalr) > ALUresult (as previous WB).
//  - Link value = PC+PC_INC mod 2^XLEN (wraps, no carry out).
//  - Load extract: off=ALUresult[1:0]; byte=rdata[8*off+:8];
//    half=rdata[16*off[1]+:16] (off[0] ignored). funct3 000 LB sext,
//    001 LH sext, 100 LBU zext, 101 LHU zext, 010 and others: full word.
//  - Strobe: Ctl_RegWrite_out=1 for exactly one cycle per retirement with
//    RegWrite=1 and Rd!=0; Rd==0 retires with strobe 0, data still driven.
//  - Between retirements Ctl_RegWrite_out=0; Rd_out/data hold last value.
//  - flush_in: state->IDLE, pending dropped, no strobe; flush beats a
//    same-cycle mem_rvalid and a same-cycle accept (accept ignored).
//  - reset beats flush; reset in WAIT_MEM drops the load, late rvalid ignored.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: 64-bit retire_cnt increments by 1 on every
//    retirement (incl. Rd==0, excl. flushed), wraps at 2^64, clears on reset.
//  Not defined: retire_cnt port absent; no counter logic.
// TESTING
//  1 reset, then ALU op Rd=5 ALU=0x1234 -> next cycle strobe=1, Rd_out=5,
//    data=0x1234; following cycle strobe=0.
//  2 jal PC=0xFFFFFFFC Rd=1 -> data=0x00000000 (wrap), strobe=1.
//  3 LB off=3 rdata=0x80FF_0000, rvalid same cycle -> data=0xFFFFFF80;
//    LHU off=2 same word -> 0x000080FF.
//  4 LW Rd=7, rvalid 3 cycles late rdata=0xDEADBEEF -> in_ready=0 for 3
//    cycles, strobe 1 cycle after rvalid, data=0xDEADBEEF, in_ready=1.
//  5 load pending + flush_in with rvalid same cycle -> no strobe, IDLE;
//    Rd=0 ALU op -> strobe=0; stray rvalid in IDLE -> no strobe.
//  6 WB_RETIRE_CNT_EN: 10 retirements incl. one Rd=0, one flushed ->
//    retire_cnt=9; reset mid-WAIT_MEM -> retire_cnt=0, in_ready=1.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage between MEM and the register file.
// Accepts one instruction per valid/ready handshake. A load whose data has not
// arrived is parked in WAIT_MEM until mem_rvalid. The stage then extracts the
// byte or half with sign or zero extension, suppresses writes to x0 and
// supports flush.
// Optional feature: define WB_RETIRE_CNT_EN to add a 64-bit retire counter
// (retire_cnt port).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid / in_ready    handshake from MEM (ready only in IDLE)
//   flush_in               drop pending load, return to IDLE
//   Ctl_*_in, jal_in, jalr_in, funct3_in, PC_in, Rd_in, ALUresult_in
//                          instruction payload from MEM
//   mem_rvalid, mem_rdata  load data return (may lag accept)
//   Ctl_RegWrite_out, Rd_out, WriteDatatoReg_out
//                          register file write port (one-cycle strobe)
//   retire_cnt             retired instruction count (WB_RETIRE_CNT_EN only)
module wb_stage_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush_in,
  input  logic                  Ctl_RegWrite_in,
  input  logic                  Ctl_MemtoReg_in,
  input  logic                  jal_in,
  input  logic                  jalr_in,
  input  logic [2:0]            funct3_in,
  input  logic [XLEN-1:0]       PC_in,
  input  logic [REG_ADDR_W-1:0] Rd_in,
  input  logic [XLEN-1:0]       ALUresult_in,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  Ctl_RegWrite_out,
  output logic [REG_ADDR_W-1:0] Rd_out,
  output logic [XLEN-1:0]       WriteDatatoReg_out
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           retire_cnt
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t                state;
  logic                  pend_we;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic [2:0]            pend_f3;
  logic [1:0]            pend_off;

  logic                  accept_c;
  logic                  park_c;
  logic                  retire_c;
  logic                  ret_we_c;
  logic [REG_ADDR_W-1:0] ret_rd_c;
  logic [XLEN-1:0]       ret_data_c;

  // Writeback value selection: load extract > link > ALU result.
  function automatic logic [XLEN-1:0] wb_result(
    input logic            memtoreg,
    input logic            link,
    input logic [2:0]      f3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] rdata
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    if (memtoreg) begin
      case (f3)
        3'b000:  r = {{(XLEN-8){b[7]}}, b};
        3'b001:  r = {{(XLEN-16){h[15]}}, h};
        3'b100:  r = XLEN'(b);
        3'b101:  r = XLEN'(h);
        default: r = rdata;
      endcase
    end else if (link) begin
      r = pc + XLEN'(PC_INC);
    end else begin
      r = alu;
    end
    return r;
  endfunction

  // Decide this cycle's action; flush and reset suppress everything.
  always_comb begin
    accept_c   = 1'b0;
    park_c     = 1'b0;
    retire_c   = 1'b0;
    ret_we_c   = 1'b0;
    ret_rd_c   = '0;
    ret_data_c = '0;
    if (!reset && !flush_in) begin
      if (state == IDLE) begin
        accept_c = in_valid;
        park_c   = in_valid && Ctl_MemtoReg_in && !mem_rvalid;
        retire_c = accept_c && !park_c;
        ret_we_c = Ctl_RegWrite_in;
        ret_rd_c = Rd_in;
        ret_data_c = wb_result(Ctl_MemtoReg_in, jal_in | jalr_in, funct3_in,
                               ALUresult_in[1:0], PC_in, ALUresult_in, mem_rdata);
      end else begin
        retire_c = mem_rvalid;
        ret_we_c = pend_we;
        ret_rd_c = pend_rd;
        ret_data_c = wb_result(1'b1, 1'b0, pend_f3, pend_off,
                               XLEN'(0), XLEN'(0), mem_rdata);
      end
    end
  end

  // FSM, parked-load registers and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      in_ready           <= 1'b1;
      pend_we            <= 1'b0;
      pend_rd            <= '0;
      pend_f3            <= '0;
      pend_off           <= '0;
      Ctl_RegWrite_out   <= 1'b0;
      Rd_out             <= '0;
      WriteDatatoReg_out <= '0;
    end else if (flush_in) begin
      state            <= IDLE;
      in_ready         <= 1'b1;
      Ctl_RegWrite_out <= 1'b0;
    end else begin
      Ctl_RegWrite_out <= 1'b0;
      case (state)
        IDLE: begin
          if (park_c) begin
            state    <= WAIT_MEM;
            in_ready <= 1'b0;
            pend_we  <= Ctl_RegWrite_in;
            pend_rd  <= Rd_in;
            pend_f3  <= funct3_in;
            pend_off <= ALUresult_in[1:0];
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
      if (retire_c) begin
        Ctl_RegWrite_out   <= ret_we_c && (ret_rd_c != '0);
        Rd_out             <= ret_rd_c;
        WriteDatatoReg_out <= ret_data_c;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts every retirement, including x0 writes; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (retire_c) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`else
  // No retire counter in this build.
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush_in;
  logic        Ctl_RegWrite_in;
  logic        Ctl_MemtoReg_in;
  logic        jal_in;
  logic        jalr_in;
  logic [2:0]  funct3_in;
  logic [31:0] PC_in;
  logic [4:0]  Rd_in;
  logic [31:0] ALUresult_in;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        Ctl_RegWrite_out;
  logic [4:0]  Rd_out;
  logic [31:0] WriteDatatoReg_out;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int total = 0;
  int bad   = 0;

  wb_stage_pipe dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .flush_in           (flush_in),
    .Ctl_RegWrite_in    (Ctl_RegWrite_in),
    .Ctl_MemtoReg_in    (Ctl_MemtoReg_in),
    .jal_in             (jal_in),
    .jalr_in            (jalr_in),
    .funct3_in          (funct3_in),
    .PC_in              (PC_in),
    .Rd_in              (Rd_in),
    .ALUresult_in       (ALUresult_in),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .Ctl_RegWrite_out   (Ctl_RegWrite_out),
    .Rd_out             (Rd_out),
    .WriteDatatoReg_out (WriteDatatoReg_out)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt         (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of a retired instruction's write value.
  function automatic logic [31:0] ref_value(input logic ld, input logic link,
                                            input logic [2:0] f3, input logic [31:0] pc,
                                            input logic [31:0] alu, input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * alu[1:0])) & 32'hFF;
    h = (rdata >> (16 * alu[1])) & 32'hFFFF;
    if (ld) begin
      case (f3)
        3'd0:    return (b ^ 32'h80) - 32'h80;
        3'd1:    return (h ^ 32'h8000) - 32'h8000;
        3'd4:    return b;
        3'd5:    return h;
        default: return rdata;
      endcase
    end
    if (link) return pc + 32'd4;
    return alu;
  endfunction

  // Behavioural model: one pending-load slot plus the last write seen.
  bit          m_live = 0;
  bit          m_pend = 0;
  logic        m_strobe = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_data = 0;
  logic [63:0] m_cnt = 0;
  logic        p_we;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  logic [31:0] p_alu;

  task automatic m_retire(input logic we, input logic [4:0] rd, input logic [31:0] v);
    m_strobe = we && (rd != 5'd0);
    m_rd     = rd;
    m_data   = v;
    m_cnt    = m_cnt + 64'd1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_pend = 0; m_strobe = 0; m_rd = 0; m_data = 0; m_cnt = 0;
    end else if (flush_in) begin
      m_pend = 0; m_strobe = 0;
    end else begin
      m_strobe = 0;
      if (m_pend) begin
        if (mem_rvalid) begin
          m_retire(p_we, p_rd, ref_value(1'b1, 1'b0, p_f3, 32'd0, p_alu, mem_rdata));
          m_pend = 0;
        end
      end else if (in_valid) begin
        if (Ctl_MemtoReg_in && !mem_rvalid) begin
          m_pend = 1; p_we = Ctl_RegWrite_in; p_rd = Rd_in; p_f3 = funct3_in; p_alu = ALUresult_in;
        end else begin
          m_retire(Ctl_RegWrite_in, Rd_in,
                   ref_value(Ctl_MemtoReg_in, jal_in | jalr_in, funct3_in, PC_in, ALUresult_in, mem_rdata));
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_ready", in_ready, !m_pend);
      chk("m_strobe", Ctl_RegWrite_out, m_strobe);
      chk("m_rd", Rd_out, m_rd);
      chk("m_data", WriteDatatoReg_out, m_data);
`ifdef WB_RETIRE_CNT_EN
      chk("m_cnt", retire_cnt, m_cnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush_in = 0; Ctl_RegWrite_in = 0; Ctl_MemtoReg_in = 0;
    jal_in = 0; jalr_in = 0; funct3_in = 3'd2; PC_in = 0; Rd_in = 0;
    ALUresult_in = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] v);
    idle_inputs();
    in_valid = 1; Ctl_RegWrite_in = 1; Rd_in = rd; ALUresult_in = v;
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic rv, input logic [31:0] rdata);
    idle_inputs();
    in_valid = 1; Ctl_RegWrite_in = 1; Ctl_MemtoReg_in = 1; Rd_in = rd;
    funct3_in = f3; ALUresult_in = addr; mem_rvalid = rv; mem_rdata = rdata;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_ready", in_ready, 1);
    chk("rst_strobe", Ctl_RegWrite_out, 0);
    chk("rst_data", WriteDatatoReg_out, 0);

    // ALU op
    alu_op(5'd5, 32'h1234);
    tick();
    chk("alu_strobe", Ctl_RegWrite_out, 1);
    chk("alu_rd", Rd_out, 5);
    chk("alu_data", WriteDatatoReg_out, 32'h1234);
    idle_inputs();
    tick();
    chk("alu_strobe_drop", Ctl_RegWrite_out, 0);
    chk("alu_data_hold", WriteDatatoReg_out, 32'h1234);

    // jal link wraps
    idle_inputs();
    in_valid = 1; Ctl_RegWrite_in = 1; jal_in = 1; PC_in = 32'hFFFF_FFFC; Rd_in = 5'd1;
    ALUresult_in = 32'h5555;
    tick();
    chk("jal_data", WriteDatatoReg_out, 32'h0);
    chk("jal_strobe", Ctl_RegWrite_out, 1);

    // byte / half extraction with immediate data
    load_op(5'd3, 3'd0, 32'h103, 1, 32'h80FF_0000);
    tick();
    chk("lb_data", WriteDatatoReg_out, 32'hFFFF_FF80);
    load_op(5'd3, 3'd5, 32'h102, 1, 32'h80FF_0000);
    tick();
    chk("lhu_data", WriteDatatoReg_out, 32'h0000_80FF);

    // late load data
    load_op(5'd7, 3'd2, 32'h200, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_wait_ready", in_ready, 0);
      chk("lw_wait_strobe", Ctl_RegWrite_out, 0);
      idle_inputs();
    end
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("lw_strobe", Ctl_RegWrite_out, 1);
    chk("lw_rd", Rd_out, 7);
    chk("lw_data", WriteDatatoReg_out, 32'hDEAD_BEEF);
    chk("lw_ready", in_ready, 1);

    // flush beats same-cycle rvalid
    load_op(5'd9, 3'd2, 32'h300, 0, 32'h0);
    tick();
    idle_inputs();
    flush_in = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    tick();
    chk("flush_strobe", Ctl_RegWrite_out, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_data_hold", WriteDatatoReg_out, 32'hDEAD_BEEF);
    // flush beats same-cycle accept
    alu_op(5'd4, 32'h77);
    flush_in = 1;
    tick();
    chk("flush_accept_strobe", Ctl_RegWrite_out, 0);
    alu_op(5'd0, 32'hABCD);
    tick();
    chk("x0_strobe", Ctl_RegWrite_out, 0);
    chk("x0_data", WriteDatatoReg_out, 32'hABCD);
    idle_inputs();
    mem_rvalid = 1; mem_rdata = 32'h9999;
    tick();
    chk("stray_rvalid_strobe", Ctl_RegWrite_out, 0);
    chk("stray_rvalid_data", WriteDatatoReg_out, 32'hABCD);

    // retire counting: 9 retirements (one x0) plus one flushed load
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 9; i++) begin
      alu_op((i == 4) ? 5'd0 : 5'(i + 1), 32'(i));
      tick();
    end
    load_op(5'd2, 3'd2, 32'h0, 0, 32'h0);
    tick();
    idle_inputs();
    flush_in = 1;
    tick();
    idle_inputs();
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_nine", retire_cnt, 64'd9);
`endif
    load_op(5'd2, 3'd2, 32'h0, 0, 32'h0);
    tick();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    mem_rvalid = 1; mem_rdata = 32'h1;
    chk("reset_wait_ready", in_ready, 1);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_reset", retire_cnt, 64'd0);
`endif
    tick();
    chk("reset_late_rvalid_strobe", Ctl_RegWrite_out, 0);

    // randomized traffic checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      reset           = ($urandom_range(0, 299) == 0);
      flush_in        = ($urandom_range(0, 15) == 0);
      in_valid        = $urandom_range(0, 1) == 1;
      Ctl_RegWrite_in = $urandom_range(0, 3) != 0;
      Ctl_MemtoReg_in = $urandom_range(0, 2) == 0;
      jal_in          = $urandom_range(0, 5) == 0;
      jalr_in         = $urandom_range(0, 5) == 0;
      funct3_in       = 3'($urandom_range(0, 7));
      PC_in           = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      Rd_in           = 5'($urandom_range(0, 7));
      ALUresult_in    = $urandom;
      mem_rvalid      = $urandom_range(0, 2) == 0;
      mem_rdata       = $urandom;
      tick();
    end
    idle_inputs();
    reset = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
